// File: rtl/muldiv_pkg.sv
// Shared decode constants and state encoding for the HI/LO multiply-divide unit.
package muldiv_pkg;

    localparam logic [5:0] FUNC_MFHI  = 6'h10;
    localparam logic [5:0] FUNC_MTHI  = 6'h11;
    localparam logic [5:0] FUNC_MFLO  = 6'h12;
    localparam logic [5:0] FUNC_MTLO  = 6'h13;
    localparam logic [5:0] FUNC_MULT  = 6'h18;
    localparam logic [5:0] FUNC_MULTU = 6'h19;
    localparam logic [5:0] FUNC_DIV   = 6'h1A;
    localparam logic [5:0] FUNC_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// One-bit-per-cycle shift-add multiplier / restoring divider sharing one 2*WIDTH accumulator.
// Multiply: acc = {partial, multiplier}. Divide: acc = {remainder, dividend/quotient}.
module muldiv_datapath #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             load_div_i,
    input  logic             step_i,
    input  logic             step_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] res_hi_o,
    output logic [WIDTH-1:0] res_lo_o
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rsh;
    logic [WIDTH-1:0]   sub;
    logic               ge;

    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rsh     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        ge      = rsh >= {1'b0, opnd_q};
        // remainder after a successful subtract is below the divisor, so WIDTH bits suffice
        sub     = rsh[WIDTH-1:0] - opnd_q;
        acc_d   = acc_q;
        if (step_i) begin
            if (step_div_i) begin
                if (ge) acc_d = {sub, acc_q[WIDTH-2:0], 1'b1};
                else    acc_d = {rsh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
        end else if (load_i) begin
            opnd_q <= load_div_i ? b_i : a_i;
            acc_q  <= {{WIDTH{1'b0}}, (load_div_i ? a_i : b_i)};
            cnt_q  <= CNT_W'(WIDTH - 1);
        end else if (step_i) begin
            acc_q <= acc_d;
            if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
    end

    // Results are taken from the step being applied, so commit lands on the last-iteration edge.
    assign last_o   = (cnt_q == '0);
    assign res_hi_o = acc_d[2*WIDTH-1:WIDTH];
    assign res_lo_o = acc_d[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply-divide unit: func decode, control FSM and architectural HI/LO registers.
// Define MULDIV_SIGNED_EN to also accept signed MULT/DIV with commit-edge sign fix-up.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_e        state_q;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic             idle_like, accept, is_mul, is_div;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             dp_last;
    logic [WIDTH-1:0] dp_hi, dp_lo, res_hi, res_lo;

`ifdef MULDIV_SIGNED_EN
    logic             sgn_op;
    logic             neg_a_q, neg_b_q, bzero_q;
    logic             neg_p;
`endif

    assign idle_like = (state_q == MD_IDLE) || (state_q == MD_DONE);
    assign accept    = idle_like && start && !flush;

    always_comb begin
        is_mul = (func == FUNC_MULTU);
        is_div = (func == FUNC_DIVU);
        a_mag  = src_a;
        b_mag  = src_b;
`ifdef MULDIV_SIGNED_EN
        sgn_op = (func == FUNC_MULT) || (func == FUNC_DIV);
        if (func == FUNC_MULT) is_mul = 1'b1;
        if (func == FUNC_DIV)  is_div = 1'b1;
        if (sgn_op && src_a[WIDTH-1]) a_mag = -src_a;
        if (sgn_op && src_b[WIDTH-1]) b_mag = -src_b;
`endif
    end

    muldiv_datapath #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_dp (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept && (is_mul || is_div)),
        .load_div_i (is_div),
        .step_i     ((state_q == MD_MUL || state_q == MD_DIV) && !flush),
        .step_div_i (state_q == MD_DIV),
        .a_i        (a_mag),
        .b_i        (b_mag),
        .last_o     (dp_last),
        .res_hi_o   (dp_hi),
        .res_lo_o   (dp_lo)
    );

    always_comb begin
        res_hi = dp_hi;
        res_lo = dp_lo;
`ifdef MULDIV_SIGNED_EN
        neg_p = neg_a_q ^ neg_b_q;
        if (state_q == MD_MUL) begin
            if (neg_p) {res_hi, res_lo} = -{dp_hi, dp_lo};
        end else begin
            // remainder follows the dividend sign, which also restores src_a on divide-by-zero
            res_hi = neg_a_q ? -dp_hi : dp_hi;
            if (bzero_q)    res_lo = '1;
            else if (neg_p) res_lo = -dp_lo;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            bzero_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                MD_IDLE, MD_DONE: begin
                    state_q <= MD_IDLE;
                    if (accept) begin
                        if (is_mul) begin
                            state_q <= MD_MUL;
                            busy_q  <= 1'b1;
                        end else if (is_div) begin
                            state_q <= MD_DIV;
                            busy_q  <= 1'b1;
                        end else if (func == FUNC_MTHI) begin
                            hi_q <= src_a;
                        end else if (func == FUNC_MTLO) begin
                            lo_q <= src_a;
                        end
`ifdef MULDIV_SIGNED_EN
                        neg_a_q <= sgn_op && src_a[WIDTH-1];
                        neg_b_q <= sgn_op && src_b[WIDTH-1];
                        bzero_q <= (src_b == '0);
`endif
                    end
                end
                MD_MUL, MD_DIV: begin
                    if (flush) begin
                        state_q <= MD_IDLE;
                        busy_q  <= 1'b0;
                    end else if (dp_last) begin
                        state_q <= MD_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        hi_q    <= res_hi;
                        lo_q    <= res_lo;
                    end
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
